// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: self-test controller for a small combinational gate.
// Sweeps every input vector 0..2**N_IN-1, holds each for SETTLE_CYC+1 clocks,
// samples the gate output into a truth table and compares it to EXPECTED.
// Optional build macro: HALT_ON_MISMATCH_EN (stop the sweep at the first mismatch).
module truth_table_sweeper #(
  parameter int                     N_IN       = 3,
  parameter int                     SETTLE_CYC = 4,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED   = 'h69
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [(1<<N_IN)-1:0]    table_out,
  output logic [N_IN:0]           mismatch_cnt,
  output logic [N_IN-1:0]         fail_idx
);

  localparam int                NV          = 1 << N_IN;
  localparam int                SC_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]   LAST_IDX    = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [N_IN-1:0]   idx;
  logic [SC_W-1:0]   settle_cnt;
  logic              done_q;
  logic              accept;
  logic              mismatch;

  // Start is honoured only when no sweep is in flight.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign mismatch = (dut_out != EXPECTED[idx]);

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = done_q;
  assign pass = done_q && (mismatch_cnt == '0);

  // Next-state decode for the sweep sequencer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE: begin
`ifdef HALT_ON_MISMATCH_EN
        if (mismatch || (idx == LAST_IDX)) next_state = DONE;
        else                               next_state = SETTLE;
`else
        if (idx == LAST_IDX) next_state = DONE;
        else                 next_state = SETTLE;
`endif
      end
      DONE:   if (start) next_state = SETTLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Sweep datapath: vector drive, settle timing, table capture and scoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      settle_cnt   <= '0;
      dut_in       <= '0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
      done_q       <= 1'b0;
    end else begin
      // done is a registered view of DONE; it falls on the accepting edge.
      done_q <= (state == DONE) && !accept;
      if (accept) begin
        idx          <= '0;
        settle_cnt   <= '0;
        dut_in       <= '0;
        table_out    <= '0;
        mismatch_cnt <= '0;
        fail_idx     <= '0;
      end else begin
        case (state)
          SETTLE: settle_cnt <= settle_cnt + 1'b1;
          SAMPLE: begin
            table_out[idx] <= dut_out;
            if (mismatch) begin
              mismatch_cnt <= mismatch_cnt + 1'b1;
              if (mismatch_cnt == '0) fail_idx <= idx;
            end
            // Advance only when another vector follows; idx never wraps.
            if (next_state == SETTLE) begin
              idx        <= idx + 1'b1;
              dut_in     <= idx + 1'b1;
              settle_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
